req_encoder83: RTL

- Sequential 8-to-3 priority encoder, the inverse of the 3-to-8 decoder.
- Accumulates request bits into a sticky pending vector and selects the winning request by priority.
- Presents the winner's 3-bit index through a registered valid/ready output stage, then clears the served bit.
- Sits between event/request sources and a consumer that needs one binary index at a time.

---
 rtl/req_encoder83_pkg.sv | 9 +
 rtl/req_encoder83_prio_sel.sv | 27 ++
 rtl/req_encoder83.sv | 70 +++++++
 3 files changed

// File: rtl/req_encoder83_pkg.sv
// Shared sizing defaults and vector types for the sequential 8-to-3 request encoder.
package req_encoder83_pkg;
  localparam int N         = 8;
  localparam int W         = 3;
  localparam bit PRIO_HIGH = 1'b1;

  typedef logic [N-1:0] req_t;
  typedef logic [W-1:0] idx_t;
endpackage

// File: rtl/req_encoder83_prio_sel.sv
// Combinational priority selector: reports the winning set bit of vec and whether any bit is set.
module prio_sel
  import req_encoder83_pkg::*;
#(
  parameter int N         = req_encoder83_pkg::N,
  parameter int W         = req_encoder83_pkg::W,
  parameter bit PRIO_HIGH = req_encoder83_pkg::PRIO_HIGH
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // The last matching bit in scan order wins, so scan direction sets the priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (PRIO_HIGH) begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/req_encoder83.sv
// Sticky-pending 8-to-3 priority encoder with a registered valid/ready output stage.
module req_encoder83
  import req_encoder83_pkg::*;
#(
  parameter int N         = req_encoder83_pkg::N,
  parameter int W         = req_encoder83_pkg::W,
  parameter bit PRIO_HIGH = req_encoder83_pkg::PRIO_HIGH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [W:0]   pend_cnt,
  output logic         any_pend
);

  logic [N-1:0] pending;
  logic [N-1:0] clear_mask;
  logic [N-1:0] pending_next;
  logic [W-1:0] sel;
  logic         sel_any;
  logic         load;

  prio_sel #(
    .N         (N),
    .W         (W),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_prio_sel (
    .vec (pending),
    .idx (sel),
    .any (sel_any)
  );

  assign load = !out_valid || out_ready;

  // New requests are OR-ed in after the clear, so a same-cycle re-request keeps its bit.
  always_comb begin
    clear_mask = '0;
    if (load && sel_any)
      clear_mask[sel] = 1'b1;
    pending_next = (pending & ~clear_mask) | (en ? req : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      pending <= pending_next;
      if (load) begin
        out_valid <= sel_any;
        if (sel_any)
          out_idx <= sel;
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N; i++)
      pend_cnt = pend_cnt + (W+1)'(pending[i]);
  end

  assign any_pend = |pending;

endmodule
